harris_grad_accum: RTL and testbench

- Streaming Harris structure-tensor unit that generalises the single-channel lgxx compute stage.
- Each accepted beat carries a 3x3 pixel window. The unit computes Sobel gx/gy, clamps them, and forms the xx, yy and xy products scaled by an arithmetic right shift.
- Products are accumulated over ACC_LEN beats, and one three-channel result is emitted per group.
- Sits between the padded-input line buffer and the corner-response unit. Valid/ready on both sides.

---
 rtl/harris_grad_accum_pkg.sv | 33 +++
 rtl/harris_grad_accum_sobel_clamp.sv | 37 +++
 rtl/harris_grad_accum.sv | 127 ++++++++++++
 tb/tb_harris_grad_accum.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/harris_grad_accum_pkg.sv
// Shared constants, window indices, clamp helper and tensor type for the
// Harris structure-tensor accumulator.
package harris_pkg;

  localparam int unsigned HARRIS_W     = 16;
  localparam int unsigned HARRIS_CLAMP = 255;
  localparam int unsigned HARRIS_SHIFT = 7;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 2;
  localparam int unsigned P3 = 3;
  localparam int unsigned P4 = 4;
  localparam int unsigned P5 = 5;
  localparam int unsigned P6 = 6;
  localparam int unsigned P7 = 7;
  localparam int unsigned P8 = 8;

  typedef struct packed {
    logic signed [HARRIS_W-1:0] xx;
    logic signed [HARRIS_W-1:0] yy;
    logic signed [HARRIS_W-1:0] xy;
  } tensor_t;

  // smin(x, bound) then smax(., -bound); operands are sign-extended to 32 bits
  function automatic logic signed [31:0] sclamp(input logic signed [31:0] x,
                                                input logic signed [31:0] bound);
    logic signed [31:0] t;
    t = (x > bound) ? bound : x;
    return (t < -bound) ? -bound : t;
  endfunction

endpackage

// File: rtl/harris_grad_accum_sobel_clamp.sv
// Combinational Sobel gx/gy over a row-major 3x3 window, W-bit wrapping,
// clamped to [-CLAMP, CLAMP]. W must not exceed 32.
module harris_sobel_clamp
  import harris_pkg::*;
#(
  parameter int unsigned W     = HARRIS_W,
  parameter int unsigned CLAMP = HARRIS_CLAMP
) (
  input  logic [9*W-1:0] win,
  output logic [W-1:0]   gx,
  output logic [W-1:0]   gy
);

  logic [W-1:0]        p0, p1, p2, p3, p5, p6, p7, p8;
  logic signed [W-1:0] gx_raw, gy_raw;
  logic                unused_center;

  assign p0 = win[P0*W +: W];
  assign p1 = win[P1*W +: W];
  assign p2 = win[P2*W +: W];
  assign p3 = win[P3*W +: W];
  assign p5 = win[P5*W +: W];
  assign p6 = win[P6*W +: W];
  assign p7 = win[P7*W +: W];
  assign p8 = win[P8*W +: W];

  // The Sobel kernels have a zero centre tap.
  assign unused_center = ^win[P4*W +: W];

  always_comb begin
    gx_raw = (p2 + (p5 << 1) + p8) - (p0 + (p3 << 1) + p6);
    gy_raw = (p6 + (p7 << 1) + p8) - (p0 + (p1 << 1) + p2);
    gx     = W'(sclamp(32'(gx_raw), 32'(CLAMP)));
    gy     = W'(sclamp(32'(gy_raw), 32'(CLAMP)));
  end

endmodule

// File: rtl/harris_grad_accum.sv
// Streaming Harris structure-tensor unit: Sobel+clamp, scaled xx/yy/xy
// products, and a per-group accumulator with valid/ready on both sides.
module harris_grad_accum
  import harris_pkg::*;
#(
  parameter int unsigned W       = HARRIS_W,
  parameter int unsigned CLAMP   = HARRIS_CLAMP,
  parameter int unsigned SHIFT   = HARRIS_SHIFT,
  parameter int unsigned ACC_LEN = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [9*W-1:0] in_win,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_xx,
  output logic [W-1:0]   out_yy,
  output logic [W-1:0]   out_xy
);

  localparam int unsigned   CW   = $clog2(ACC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  typedef struct packed {
    logic signed [W-1:0] xx;
    logic signed [W-1:0] yy;
    logic signed [W-1:0] xy;
  } chan_t;

  logic                stall;
  logic [W-1:0]        gx_c, gy_c;
  logic                v1, v2;
  logic signed [W-1:0] gx1, gy1;
  logic signed [W-1:0] mxx, myy, mxy;
  chan_t               prod, acc, acc_nxt;
  logic [CW-1:0]       cnt;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  harris_sobel_clamp #(
    .W     (W),
    .CLAMP (CLAMP)
  ) u_sobel (
    .win (in_win),
    .gx  (gx_c),
    .gy  (gy_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      gx1 <= '0;
      gy1 <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (!stall) begin
      v1  <= in_valid;
      gx1 <= gx_c;
      gy1 <= gy_c;
    end
  end

  // Products keep only the low W bits before the arithmetic shift.
  always_comb begin
    mxx = gx1 * gx1;
    myy = gy1 * gy1;
    mxy = gx1 * gy1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      prod <= '0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (!stall) begin
      v2      <= v1;
      prod.xx <= mxx >>> SHIFT;
      prod.yy <= myy >>> SHIFT;
      prod.xy <= mxy >>> SHIFT;
    end
  end

  always_comb begin
    acc_nxt.xx = ((cnt == '0) ? '0 : acc.xx) + prod.xx;
    acc_nxt.yy = ((cnt == '0) ? '0 : acc.yy) + prod.yy;
    acc_nxt.xy = ((cnt == '0) ? '0 : acc.xy) + prod.xy;
  end

  // A drained result and a freshly completed group may share a cycle;
  // the later assignment keeps out_valid high with the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_xx    <= '0;
      out_yy    <= '0;
      out_xy    <= '0;
    end else if (flush) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (v2 && !stall) begin
        if (cnt == LAST) begin
          out_xx    <= acc_nxt.xx;
          out_yy    <= acc_nxt.yy;
          out_xy    <= acc_nxt.xy;
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_harris_grad_accum.sv
// Directed and randomized bench for harris_grad_accum with a behavioural
// scoreboard computed from window arithmetic.
module tb_harris_grad_accum;
  import harris_pkg::*;

  localparam int unsigned GRP = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [143:0] in_win;
  logic [15:0]  out_xx, out_yy, out_xy;

  logic         flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [143:0] in_win1;
  logic [15:0]  out_xx1, out_yy1, out_xy1;

  harris_grad_accum #(.W(16), .CLAMP(255), .SHIFT(7), .ACC_LEN(9)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xx(out_xx), .out_yy(out_yy), .out_xy(out_xy)
  );

  harris_grad_accum #(.W(16), .CLAMP(255), .SHIFT(7), .ACC_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_win(in_win1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_xx(out_xx1), .out_yy(out_yy1), .out_xy(out_xy1)
  );

  int      total = 0;
  int      bad   = 0;
  tensor_t exp_q[$];
  int      part_xx, part_yy, part_xy, part_n;
  logic    hold_prev;
  tensor_t held;
  logic    last_acc;
  logic [143:0] w10, w20, w100;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: Sobel with 16-bit wrap, clamp, product wrapped to 16 bits, >>> 7.
  function automatic void model_prod(input logic [143:0] w, output int pxx, output int pyy,
                                     output int pxy);
    int p[9];
    int gx, gy;
    shortint t;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*16 +: 16]);
    gx = int'(shortint'((p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6])));
    gy = int'(shortint'((p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2])));
    gx = (gx > 255) ? 255 : ((gx < -255) ? -255 : gx);
    gy = (gy > 255) ? 255 : ((gy < -255) ? -255 : gy);
    t = shortint'(gx * gx); pxx = int'(t) >>> 7;
    t = shortint'(gy * gy); pyy = int'(t) >>> 7;
    t = shortint'(gx * gy); pxy = int'(t) >>> 7;
  endfunction

  task automatic model_push(input logic [143:0] w);
    int a, b, c;
    tensor_t e;
    model_prod(w, a, b, c);
    part_xx += a; part_yy += b; part_xy += c; part_n++;
    if (part_n == GRP) begin
      e.xx = 16'(part_xx); e.yy = 16'(part_yy); e.xy = 16'(part_xy);
      exp_q.push_back(e);
      part_xx = 0; part_yy = 0; part_xy = 0; part_n = 0;
    end
  endtask

  task automatic model_clear();
    part_xx = 0; part_yy = 0; part_xy = 0; part_n = 0;
    exp_q.delete();
    hold_prev = 1'b0;
  endtask

  // One clock: enter at negedge, sample 1 time unit before posedge, return at next negedge.
  task automatic cyc();
    logic    acc_s, xfer_s;
    tensor_t obs, e;
    #4;
    acc_s  = in_valid && in_ready && !flush;
    xfer_s = out_valid && out_ready && !flush;
    chk("in_ready_rule", {15'd0, in_ready}, {15'd0, !(out_valid && !out_ready)});
    if (hold_prev) begin
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_xx", out_xx, held.xx);
      chk("hold_yy", out_yy, held.yy);
      chk("hold_xy", out_xy, held.xy);
    end
    hold_prev = out_valid && !out_ready && !flush;
    held.xx = out_xx; held.yy = out_yy; held.xy = out_xy;
    obs = held;
    @(posedge clk);
    @(negedge clk);
    last_acc = acc_s;
    if (acc_s) model_push(in_win);
    if (xfer_s) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected observed=%0h expected=none", obs);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_xx", obs.xx, e.xx);
        chk("sb_yy", obs.yy, e.yy);
        chk("sb_xy", obs.xy, e.xy);
      end
    end
  endtask

  task automatic group_check(input string tag, input logic [143:0] w,
                             input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] exy);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_win   = w;
      cyc();
      chk({tag, "_accept"}, {15'd0, last_acc}, 16'd1);
    end
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {15'd0, out_valid}, 16'd0);
    cyc();
    chk({tag, "_lat2"}, {15'd0, out_valid}, 16'd0);
    cyc();
    chk({tag, "_lat3"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_xx"}, out_xx, ex);
    chk({tag, "_yy"}, out_yy, ey);
    chk({tag, "_xy"}, out_xy, exy);
    cyc();
    chk({tag, "_drained"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          got;
    logic [159:0] r;

    w10 = '0;  w10[2*16 +: 16] = 16'd10;  w10[5*16 +: 16] = 16'd10;  w10[8*16 +: 16] = 16'd10;
    w20 = '0;  w20[8*16 +: 16] = 16'd20;
    w100 = '0; w100[2*16 +: 16] = 16'd100; w100[5*16 +: 16] = 16'd100; w100[8*16 +: 16] = 16'd100;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_win = '0; out_ready = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; in_win1 = '0; out_ready1 = 1'b1;
    model_clear();
    last_acc = 1'b0;
    held = '0;

    @(negedge clk);
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_xx", out_xx, 16'd0);
    chk("rst_yy", out_yy, 16'd0);
    chk("rst_xy", out_xy, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    group_check("t_gx40", w10, 16'd108, 16'd0, 16'd0);
    group_check("t_p8", w20, 16'd27, 16'd27, 16'd27);
    group_check("t_clamp", w100, 16'hFFDC, 16'd0, 16'd0);

    // Flush a partial group; the beat presented with flush must be dropped.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_win = w10; cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    flush = 1'b1; in_valid = 1'b1; in_win = w20;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    part_xx = 0; part_yy = 0; part_xy = 0; part_n = 0;
    chk("fl_valid", {15'd0, out_valid}, 16'd0);
    chk("fl_hold_xx", out_xx, 16'hFFDC);
    group_check("fl_fresh", w10, 16'd108, 16'd0, 16'd0);

    // Backpressure with a result pending while more beats are offered.
    got = 0;
    for (int i = 0; i < 60 && got < 18; i++) begin
      out_ready = (i >= 16);
      in_valid  = 1'b1;
      in_win    = (got < 9) ? w20 : w10;
      cyc();
      if (last_acc) got++;
      if (i == 14) begin
        chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
        chk("bp_valid", {15'd0, out_valid}, 16'd1);
        chk("bp_xx", out_xx, 16'd27);
      end
    end
    chk("bp_all_accepted", 16'(got), 16'd18);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("bp_drained", 16'(exp_q.size()), 16'd0);
    chk("bp_last_xx", out_xx, 16'd108);

    // Asynchronous reset in the middle of a group.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_win = w20; cyc();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", {15'd0, out_valid}, 16'd0);
    chk("mr_xx", out_xx, 16'd0);
    chk("mr_yy", out_yy, 16'd0);
    chk("mr_xy", out_xy, 16'd0);
    chk("mr_in_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    group_check("mr_fresh", w20, 16'd27, 16'd27, 16'd27);

    // Single-beat groups alternate between a p8 window and an all-zero one.
    for (int j = 0; j < 12; j++) begin
      in_valid1 = (j < 8);
      in_win1   = (j % 2 == 0) ? w20 : '0;
      cyc();
      if (j >= 2) begin
        chk("a1_valid", {15'd0, out_valid1}, (j - 2 < 8) ? 16'd1 : 16'd0);
        if (j - 2 < 8) begin
          chk("a1_xx", out_xx1, ((j - 2) % 2 == 0) ? 16'd3 : 16'd0);
          chk("a1_yy", out_yy1, ((j - 2) % 2 == 0) ? 16'd3 : 16'd0);
          chk("a1_xy", out_xy1, ((j - 2) % 2 == 0) ? 16'd3 : 16'd0);
        end
      end
    end
    in_valid1 = 1'b0;

    // Random windows, random valid and random backpressure.
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      in_win    = r[143:0];
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("rnd_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
